// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse position tracker:
// status byte layout, FSM encoding and default screen limits.
package mouse_pkg;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam int VGA_W = 160;
    localparam int VGA_H = 120;

    localparam logic [7:0] STATUS_RST = 8'h08;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CLAMP   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

endpackage

// File: rtl/mouse_axis_accum.sv
// One tracker axis: scale and add the packet delta, then clamp or wrap.
// The position register doubles as the published output.
module mouse_axis_accum
    import mouse_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MAX    = 159,
    parameter int INIT   = 0,
    parameter int WRAP   = 0,
    parameter int SHIFT  = 0,
    parameter int INVERT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_en,
    input  logic             clamp_en,
    input  logic [8:0]       delta,
    input  logic             zero,
    output logic [WIDTH-1:0] pos
);

    localparam int SW = ((WIDTH > 9) ? WIDTH : 9) + 2;
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAX);
    localparam logic [WIDTH-1:0]     MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0]     INIT_W = WIDTH'(INIT);

    logic signed [SW-1:0] d_ext;
    logic signed [SW-1:0] d_sh;
    logic signed [SW-1:0] pos_ext;
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    logic [WIDTH-1:0]     clamp_d;

    always_comb begin
        d_ext   = {{(SW-9){delta[8]}}, delta};
        d_sh    = zero ? '0 : (d_ext >>> SHIFT);
        pos_ext = {{(SW-WIDTH){1'b0}}, pos};
        sum_d   = (INVERT != 0) ? (pos_ext - d_sh) : (pos_ext + d_sh);
    end

    // Wrap keeps the two's complement low bits, so negative sums wrap too.
    always_comb begin
        clamp_d = sum_q[WIDTH-1:0];
        if (WRAP == 0) begin
            if (sum_q[SW-1])
                clamp_d = '0;
            else if (sum_q > MAX_S)
                clamp_d = MAX_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            pos   <= INIT_W;
        end else begin
            if (acc_en)
                sum_q <= sum_d;
            if (clamp_en)
                pos <= clamp_d;
        end
    end

endmodule

// File: rtl/mouse_position_tracker.sv
// Turns decoded PS/2 packets into absolute X/Y/Z with button edge
// pulses and an overflow counter, behind valid/ready handshakes.
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 8,
    parameter int Z_WIDTH    = 8,
    parameter int X_MAX      = VGA_W - 1,
    parameter int Y_MAX      = VGA_H - 1,
    parameter int Z_MAX      = 255,
    parameter int X_INIT     = VGA_W / 2,
    parameter int Y_INIT     = VGA_H / 2,
    parameter int SENS_SHIFT = 0,
    parameter int Y_INVERT   = 1,
    parameter int Z_WRAP     = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PKT_VALID,
    output logic               PKT_READY,
    input  logic [7:0]         PKT_STATUS,
    input  logic [7:0]         PKT_DX,
    input  logic [7:0]         PKT_DY,
    input  logic [7:0]         PKT_DZ,
    output logic [X_WIDTH-1:0] MOUSE_X,
    output logic [Y_WIDTH-1:0] MOUSE_Y,
    output logic [Z_WIDTH-1:0] MOUSE_Z,
    output logic [7:0]         MOUSE_STATUS,
    output logic               POS_VALID,
    input  logic               POS_READY,
    output logic [2:0]         BTN_PRESS,
    output logic [2:0]         BTN_RELEASE,
    output logic [7:0]         OVF_COUNT
);

    state_t     state;
    logic [7:0] st_q;
    logic [7:0] dx_q;
    logic [7:0] dy_q;
    logic [7:0] dz_q;
    logic       acc_en;
    logic       clamp_en;
    logic [2:0] btn_new;
    logic [2:0] btn_old;

    assign acc_en   = (state == ACCUM);
    assign clamp_en = (state == CLAMP);
    assign btn_new  = st_q[BTN_M:BTN_L];
    assign btn_old  = MOUSE_STATUS[BTN_M:BTN_L];

    mouse_axis_accum #(
        .WIDTH (X_WIDTH),
        .MAX   (X_MAX),
        .INIT  (X_INIT),
        .WRAP  (0),
        .SHIFT (SENS_SHIFT),
        .INVERT(0)
    ) u_x (
        .clk     (CLK),
        .rst_n   (RESET),
        .acc_en  (acc_en),
        .clamp_en(clamp_en),
        .delta   ({st_q[XSIGN], dx_q}),
        .zero    (st_q[XOVF]),
        .pos     (MOUSE_X)
    );

    mouse_axis_accum #(
        .WIDTH (Y_WIDTH),
        .MAX   (Y_MAX),
        .INIT  (Y_INIT),
        .WRAP  (0),
        .SHIFT (SENS_SHIFT),
        .INVERT(Y_INVERT)
    ) u_y (
        .clk     (CLK),
        .rst_n   (RESET),
        .acc_en  (acc_en),
        .clamp_en(clamp_en),
        .delta   ({st_q[YSIGN], dy_q}),
        .zero    (st_q[YOVF]),
        .pos     (MOUSE_Y)
    );

    // Wheel delta is a plain signed byte and is never scaled.
    mouse_axis_accum #(
        .WIDTH (Z_WIDTH),
        .MAX   (Z_MAX),
        .INIT  (0),
        .WRAP  (Z_WRAP),
        .SHIFT (0),
        .INVERT(0)
    ) u_z (
        .clk     (CLK),
        .rst_n   (RESET),
        .acc_en  (acc_en),
        .clamp_en(clamp_en),
        .delta   ({dz_q[7], dz_q}),
        .zero    (1'b0),
        .pos     (MOUSE_Z)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            PKT_READY    <= 1'b1;
            st_q         <= STATUS_RST;
            dx_q         <= '0;
            dy_q         <= '0;
            dz_q         <= '0;
            MOUSE_STATUS <= STATUS_RST;
            POS_VALID    <= 1'b0;
            BTN_PRESS    <= '0;
            BTN_RELEASE  <= '0;
            OVF_COUNT    <= '0;
        end else begin
            BTN_PRESS   <= '0;
            BTN_RELEASE <= '0;
            unique case (state)
                IDLE: begin
                    if (PKT_VALID) begin
                        st_q      <= PKT_STATUS;
                        dx_q      <= PKT_DX;
                        dy_q      <= PKT_DY;
                        dz_q      <= PKT_DZ;
                        PKT_READY <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    state <= CLAMP;
                end
                CLAMP: begin
                    MOUSE_STATUS <= st_q;
                    BTN_PRESS    <= btn_new & ~btn_old;
                    BTN_RELEASE  <= ~btn_new & btn_old;
                    POS_VALID    <= 1'b1;
                    if ((st_q[XOVF] | st_q[YOVF]) && (OVF_COUNT != 8'hFF))
                        OVF_COUNT <= OVF_COUNT + 8'd1;
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    if (POS_READY) begin
                        POS_VALID <= 1'b0;
                        PKT_READY <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
